// File: rtl/ok_snap_pkg.sv
// Shared types and constants for the snapshot bank.
package ok_snap_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRESH = 2'd1,
    CAPTURE    = 2'd2,
    DONE       = 2'd3
  } state_t;

endpackage

// File: rtl/ok_snap_avg.sv
// Per-channel block averager: sums 2^AVG_LOG2 samples, publishes the
// truncated mean and pulses fresh on the edge that completes a block.
module ok_snap_avg #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic              okClk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              valid,
  output logic [DATA_W-1:0] avg,
  output logic              fresh
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  // With AVG_LOG2 = 0 this is 0, so every valid completes a block.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((64'd1 << AVG_LOG2) - 64'd1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_c;
  logic [CNT_W-1:0] count;
  logic             last_c;

  assign sum_c  = acc + ACC_W'(sample);
  assign last_c = (count == CNT_LAST);

  // Accumulate, and on the final sample of a block load the mean and restart.
  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      avg   <= '0;
      fresh <= 1'b0;
    end else begin
      fresh <= 1'b0;
      if (valid) begin
        if (last_c) begin
          avg   <= DATA_W'(sum_c >> AVG_LOG2);
          acc   <= '0;
          count <= '0;
          fresh <= 1'b1;
        end else begin
          acc   <= sum_c;
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ok_snapshot_bank.sv
// Coherent multi-channel snapshot of averaged sensor data for FrontPanel
// WireOuts. A host trigger waits for every channel to publish a new average
// (or for a timeout), then copies all averages in one edge.
// Optional diagnostics counters are built when OK_SNAP_STATUS_EN is defined.
module ok_snapshot_bank
  import ok_snap_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned AVG_LOG2    = 3,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                     okClk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   sample_in,
  input  logic [N_CH-1:0]          sample_valid,
  input  logic                     snap_req,
  output logic [N_CH*WORD_W-1:0]   snap_out,
  output logic                     snap_busy,
  output logic                     snap_done,
  output logic [WORD_W-1:0]        status_word
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [N_CH*DATA_W-1:0] avg_flat;
  logic [N_CH-1:0]        fresh;
  logic [N_CH-1:0]        got_fresh;
  logic [N_CH-1:0]        got_all_c;
  logic [TMO_W-1:0]       tmo;
  state_t                 state_q;
  state_t                 state_d;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ok_snap_avg #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
      .okClk  (okClk),
      .rst    (rst),
      .sample (sample_in[c*DATA_W +: DATA_W]),
      .valid  (sample_valid[c]),
      .avg    (avg_flat[c*DATA_W +: DATA_W]),
      .fresh  (fresh[c])
    );
  end

  // A fresh pulse in the deciding cycle still counts toward completion.
  assign got_all_c = got_fresh | fresh;

  // State register.
  always_ff @(posedge okClk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; all-fresh wins over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (snap_req) state_d = WAIT_FRESH;
      WAIT_FRESH: if ((&got_all_c) || (tmo == '0)) state_d = CAPTURE;
      CAPTURE:    state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Request bookkeeping, coherent capture and registered handshake outputs.
  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      got_fresh <= '0;
      tmo       <= '0;
      snap_out  <= '0;
      snap_busy <= 1'b0;
      snap_done <= 1'b0;
    end else begin
      snap_busy <= (state_d != IDLE);
      snap_done <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (snap_req) begin
            got_fresh <= '0;
            tmo       <= TMO_W'(TIMEOUT_CYC);
          end
        end
        WAIT_FRESH: begin
          got_fresh <= got_all_c;
          if (tmo != '0) tmo <= tmo - TMO_W'(1);
        end
        CAPTURE: begin
          for (int c = 0; c < N_CH; c++) begin
            snap_out[c*WORD_W +: WORD_W] <= WORD_W'(avg_flat[c*DATA_W +: DATA_W]);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OK_SNAP_STATUS_EN
  logic [15:0]     snap_cnt;
  logic [7:0]      drop_cnt;
  logic [N_CH-1:0] stale;

  // Completed-snapshot count (wrapping), dropped requests (saturating), stale mask.
  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      snap_cnt <= '0;
      drop_cnt <= '0;
      stale    <= '0;
    end else begin
      if (state_q == CAPTURE) begin
        snap_cnt <= snap_cnt + 16'd1;
        stale    <= ~got_fresh;
      end
      if (snap_req && (state_q != IDLE) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign status_word = {8'(stale), drop_cnt, snap_cnt};
`else
  assign status_word = '0;
`endif

endmodule
